sd_frame_sequencer: RTL



---
 rtl/sd_frame_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sd_frame_sequencer.sv
// Streams 512-byte SD sectors into a double-banked frame buffer, paced to a fixed frame period.
// Optional macro SD_SEQ_BYTE_ADDR_EN: present byte addresses (sector<<9) for SDSC cards.
module sd_frame_sequencer #(
  parameter logic [31:0] START_SECTOR      = 32'd0,
  parameter int          SECTORS_PER_FRAME = 38,
  parameter int          NUM_FRAMES        = 16,
  parameter int          FB_ADDR_W         = 15,
  parameter int          FRAME_PERIOD      = 2_500_000,
  parameter int          TIMEOUT_CYCLES    = 25_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
  input  logic                 sd_ready,
  input  logic                 sd_byte_available,
  input  logic [7:0]           sd_dout,
  output logic                 sd_rd,
  output logic [31:0]          sd_address,
  output logic                 fb_we,
  output logic [FB_ADDR_W:0]   fb_addr,
  output logic [7:0]           fb_data,
  output logic                 display_bank,
  output logic [15:0]          frame_index,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 error
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_READY, S_ISSUE, S_WAIT_BUSY, S_RECV,
    S_BLOCK_END, S_FRAME_END, S_HOLD, S_ERROR
  } state_t;

  localparam logic [31:0] PERIOD_LIMIT = 32'(FRAME_PERIOD - 1);
  localparam logic [31:0] WD_LIMIT     = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]  LAST_SECTOR  = 7'(SECTORS_PER_FRAME - 1);
  localparam logic [15:0] LAST_FRAME   = 16'(NUM_FRAMES - 1);

  state_t                 state, next_state;
  logic [31:0]            sector;
  logic [31:0]            period_cnt;
  logic [31:0]            wd_cnt;
  logic [FB_ADDR_W-1:0]   offset;
  logic [8:0]             byte_cnt;
  logic [6:0]             sec_in_frame;
  logic                   write_bank;
  logic                   stop_pend;
  logic                   byte_av_q;
  logic                   byte_edge, recv_edge;
  logic                   last_sector, last_frame, period_done, watched, timeout;

`ifdef SD_SEQ_BYTE_ADDR_EN
  assign sd_address = sector << 9;
`else
  assign sd_address = sector;
`endif

  assign byte_edge   = sd_byte_available & ~byte_av_q;
  assign recv_edge   = (state == S_RECV) && byte_edge;
  assign last_sector = (sec_in_frame == LAST_SECTOR);
  assign last_frame  = (frame_index == LAST_FRAME);
  assign period_done = (period_cnt >= PERIOD_LIMIT);
  assign watched     = (state == S_WAIT_READY) || (state == S_WAIT_BUSY) ||
                       (state == S_RECV) || (state == S_BLOCK_END);
  // A byte arriving on the limit cycle counts as progress, so no write is lost to the watchdog.
  assign timeout     = watched && (wd_cnt >= WD_LIMIT) && !byte_edge;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    sd_rd      = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) next_state = S_WAIT_READY;
      end
      S_WAIT_READY: if (sd_ready) next_state = S_ISSUE;
      S_ISSUE: begin
        sd_rd      = 1'b1;
        next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!sd_ready) next_state = S_RECV;
      S_RECV: if (byte_edge && byte_cnt == 9'd511) next_state = S_BLOCK_END;
      S_BLOCK_END: begin
        if (sd_ready) begin
          if (stop_pend)        next_state = S_IDLE;
          else if (last_sector) next_state = S_FRAME_END;
          else                  next_state = S_WAIT_READY;
        end
      end
      S_FRAME_END: begin
        frame_done = 1'b1;
        next_state = S_HOLD;
      end
      S_HOLD: begin
        if (stop_pend)                      next_state = S_IDLE;
        else if (period_done && last_frame) next_state = loop_en ? S_WAIT_READY : S_IDLE;
        else if (period_done)               next_state = S_WAIT_READY;
      end
      S_ERROR: begin
        busy = 1'b0;
        if (start) next_state = S_WAIT_READY;
      end
      default: next_state = S_IDLE;
    endcase
    if (timeout) next_state = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_av_q    <= 1'b0;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= 8'd0;
      display_bank <= 1'b0;
      write_bank   <= 1'b1;
      frame_index  <= 16'd0;
      error        <= 1'b0;
      sector       <= 32'd0;
      period_cnt   <= 32'd0;
      wd_cnt       <= 32'd0;
      offset       <= '0;
      byte_cnt     <= 9'd0;
      sec_in_frame <= 7'd0;
      stop_pend    <= 1'b0;
    end else begin
      byte_av_q <= sd_byte_available;
      fb_we     <= 1'b0;

      if (!watched || next_state != state || byte_edge) wd_cnt <= 32'd0;
      else if (wd_cnt != '1)                            wd_cnt <= wd_cnt + 32'd1;

      if (state != S_IDLE && period_cnt != '1) period_cnt <= period_cnt + 32'd1;

      if (stop && busy)         stop_pend <= 1'b1;
      if (next_state == S_IDLE) stop_pend <= 1'b0;
      if (timeout)              error     <= 1'b1;

      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            sector       <= START_SECTOR;
            frame_index  <= 16'd0;
            offset       <= '0;
            period_cnt   <= 32'd0;
            byte_cnt     <= 9'd0;
            sec_in_frame <= 7'd0;
            error        <= 1'b0;
            stop_pend    <= 1'b0;
          end
        end
        S_RECV: begin
          if (recv_edge) begin
            fb_we    <= 1'b1;
            fb_data  <= sd_dout;
            fb_addr  <= {write_bank, offset};
            offset   <= offset + {{(FB_ADDR_W-1){1'b0}}, 1'b1};
            byte_cnt <= byte_cnt + 9'd1;
          end
        end
        S_BLOCK_END: begin
          if (sd_ready && !timeout) begin
            sector       <= sector + 32'd1;
            sec_in_frame <= last_sector ? 7'd0 : sec_in_frame + 7'd1;
          end
        end
        S_FRAME_END: begin
          display_bank <= write_bank;
          write_bank   <= ~write_bank;
          offset       <= '0;
        end
        S_HOLD: begin
          if (next_state == S_WAIT_READY) begin
            period_cnt <= 32'd0;
            if (last_frame) begin
              frame_index <= 16'd0;
              sector      <= START_SECTOR;
            end else begin
              frame_index <= frame_index + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
